// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles both masters' request/response signals and the
// single-port memory bus. The arbiter uses the slave modport; the side that
// issues requests and supplies memory read data uses the master modport.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          m0_req;
  logic          m0_we;
  logic          m0_lock;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic          m0_rvalid;

  logic          m1_req;
  logic          m1_we;
  logic          m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic          m1_rvalid;

  logic [DW-1:0] m_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    owner;

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_ack, m0_rvalid, m1_ack, m1_rvalid,
    output m_rdata, mem_addr, mem_wdata, mem_we, owner
  );

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_ack, m0_rvalid, m1_ack, m1_rvalid,
    input  m_rdata, mem_addr, mem_wdata, mem_we, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter in front of the single-port system memory.
// One master owns the memory port at a time; transfers are acked in the
// cycle they execute and read data comes back one cycle later.
// Build option ARB_ROUND_ROBIN_EN: when defined the masters alternate under
// contention; when undefined master 0 has fixed priority over master 1.
module mem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  mem_arbiter_if.slave bus
);

  localparam int            HW        = $clog2(MAX_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] holdCnt_q, holdCnt_d;
  logic          m0Rvalid_q, m1Rvalid_q;

  logic          m0Ack, m1Ack;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata;
  logic          memWe;
  logic          switchTo0, switchTo1;

`ifdef ARB_ROUND_ROBIN_EN
  assign switchTo0 = bus.m0_req;
  assign switchTo1 = bus.m1_req;
`else
  assign switchTo0 = bus.m0_req;
  assign switchTo1 = ~bus.m0_req & bus.m1_req;
`endif

  // Route the owner's request onto the memory port and pick the next owner.
  always_comb begin
    state_d   = state_q;
    holdCnt_d = holdCnt_q;
    m0Ack     = 1'b0;
    m1Ack     = 1'b0;
    memAddr   = '0;
    memWdata  = '0;
    memWe     = 1'b0;
    case (state_q)
      IDLE: begin
        holdCnt_d = '0;
        if (bus.m0_req)      state_d = OWN0;
        else if (bus.m1_req) state_d = OWN1;
      end
      OWN0: begin
        m0Ack    = bus.m0_req;
        memAddr  = bus.m0_addr;
        memWdata = bus.m0_wdata;
        memWe    = bus.m0_req & bus.m0_we;
        if (bus.m0_lock && bus.m0_req && (holdCnt_q < HOLD_LAST)) begin
          holdCnt_d = holdCnt_q + HW'(1);
        end else if (bus.m0_lock && !bus.m0_req) begin
          holdCnt_d = holdCnt_q;
        end else if (switchTo1) begin
          state_d   = OWN1;
          holdCnt_d = '0;
        end else begin
          holdCnt_d = '0;
        end
      end
      OWN1: begin
        m1Ack    = bus.m1_req;
        memAddr  = bus.m1_addr;
        memWdata = bus.m1_wdata;
        memWe    = bus.m1_req & bus.m1_we;
        if (bus.m1_lock && bus.m1_req && (holdCnt_q < HOLD_LAST)) begin
          holdCnt_d = holdCnt_q + HW'(1);
        end else if (bus.m1_lock && !bus.m1_req) begin
          holdCnt_d = holdCnt_q;
        end else if (switchTo0) begin
          state_d   = OWN0;
          holdCnt_d = '0;
        end else begin
          holdCnt_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        holdCnt_d = '0;
      end
    endcase
  end

  // State, burst counter and read-valid flags; reset drops any lock and pending read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      holdCnt_q  <= '0;
      m0Rvalid_q <= 1'b0;
      m1Rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      holdCnt_q  <= holdCnt_d;
      m0Rvalid_q <= m0Ack & ~bus.m0_we;
      m1Rvalid_q <= m1Ack & ~bus.m1_we;
    end
  end

  assign bus.m0_ack    = m0Ack;
  assign bus.m1_ack    = m1Ack;
  assign bus.m0_rvalid = m0Rvalid_q;
  assign bus.m1_rvalid = m1Rvalid_q;
  assign bus.m_rdata   = bus.mem_rdata;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.mem_we    = memWe;
  assign bus.owner     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven bench for mem_arbiter with MAX_HOLD = 4.
// Expectations follow ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_arbiter;

  localparam int          AW     = 16;
  localparam int          DW     = 16;
  localparam logic [15:0] ADDR0  = 16'h0010;
  localparam logic [15:0] ADDR1  = 16'h0FFF;
  localparam logic [15:0] WDATA0 = 16'h1111;
  localparam logic [15:0] WDATA1 = 16'hBEEF;
  localparam logic [15:0] D0     = 16'h1234;

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  lock;
    logic [1:0]  expAck;
    logic [1:0]  expRv;
    logic [1:0]  expOwner;
    logic [15:0] expRdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];
  vec_t handVecs[$];
  vec_t expQ[$];
  logic [15:0] f1;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [15:0] memFn(input logic [15:0] a);
    return (a == 16'h0010) ? 16'h1234 : (a ^ 16'h5A5A);
  endfunction

  // Memory model: read data appears one cycle after the address.
  always @(posedge clk) bus.mem_rdata <= memFn(bus.mem_addr);

  function automatic vec_t mk(input logic r, input logic [1:0] req, input logic [1:0] we,
                              input logic [1:0] lock, input logic [1:0] ack,
                              input logic [1:0] rv, input logic [1:0] own,
                              input logic [15:0] rd);
    vec_t v;
    v.rst = r; v.req = req; v.we = we; v.lock = lock;
    v.expAck = ack; v.expRv = rv; v.expOwner = own; v.expRdata = rd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int idx,
                             input logic [15:0] actual, input logic [15:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s row=%0d actual=%h required=%h", name, idx, actual, required);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst          = v.rst;
    bus.m0_req   = v.req[0];
    bus.m0_we    = v.we[0];
    bus.m0_lock  = v.lock[0];
    bus.m0_addr  = ADDR0;
    bus.m0_wdata = WDATA0;
    bus.m1_req   = v.req[1];
    bus.m1_we    = v.we[1];
    bus.m1_lock  = v.lock[1];
    bus.m1_addr  = ADDR1;
    bus.m1_wdata = WDATA1;
  endtask

  task automatic runRow(input int idx, input vec_t v);
    vec_t        e;
    logic [15:0] eAddr;
    logic [15:0] eWdata;
    logic        eWe;
    @(posedge clk);
    #1;
    applyStimulus(v);
    expQ.push_back(v);
    @(negedge clk);
    e = expQ.pop_front();
    eAddr  = 16'h0000;
    eWdata = 16'h0000;
    eWe    = 1'b0;
    if (e.expOwner == 2'b01) begin
      eAddr = ADDR0; eWdata = WDATA0; eWe = e.expAck[0] & e.we[0];
    end else if (e.expOwner == 2'b10) begin
      eAddr = ADDR1; eWdata = WDATA1; eWe = e.expAck[1] & e.we[1];
    end
    checkOutput("ack",       idx, 16'({bus.m1_ack, bus.m0_ack}), 16'(e.expAck));
    checkOutput("owner",     idx, 16'(bus.owner), 16'(e.expOwner));
    checkOutput("rvalid",    idx, 16'({bus.m1_rvalid, bus.m0_rvalid}), 16'(e.expRv));
    checkOutput("mem_we",    idx, 16'(bus.mem_we), 16'(eWe));
    checkOutput("mem_addr",  idx, bus.mem_addr, eAddr);
    checkOutput("mem_wdata", idx, bus.mem_wdata, eWdata);
    checkOutput("we_no_ack", idx, 16'(bus.mem_we & ~(bus.m0_ack | bus.m1_ack)), 16'h0000);
    if (e.expRv != 2'b00) checkOutput("m_rdata", idx, bus.m_rdata, e.expRdata);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog row=-1 actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    f1 = memFn(ADDR1);

    // Reset, single read, write passthrough, park and switch.
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0));
    vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0));
    vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 16'h0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, D0));
    vecs.push_back(mk(0, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 16'h0));
    vecs.push_back(mk(0, 2'b10, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 16'h0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 16'h0));
    vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 16'h0));
    vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 16'h0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, D0));
    // m1 locked writes while m0 waits: exactly four m1 acks, then m0.
    vecs.push_back(mk(0, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 16'h0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 2'b11, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 16'h0));
    vecs.push_back(mk(0, 2'b11, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 16'h0));
`ifdef ARB_ROUND_ROBIN_EN
    vecs.push_back(mk(0, 2'b11, 2'b10, 2'b00, 2'b10, 2'b01, 2'b10, D0));
    vecs.push_back(mk(0, 2'b11, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 16'h0));
    vecs.push_back(mk(0, 2'b11, 2'b10, 2'b00, 2'b10, 2'b01, 2'b10, D0));
    vecs.push_back(mk(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 16'h0));
`else
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01, D0));
    vecs.push_back(mk(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, D0));
`endif
    // Reset in the same cycle as an m1 read ack.
    vecs.push_back(mk(1, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 16'h0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0));
    // Simultaneous read requests from IDLE.
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 16'h0));
`ifdef ARB_ROUND_ROBIN_EN
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10, D0));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, f1));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, D0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 16'h0));
`else
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, D0));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, D0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, D0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 16'h0));
`endif

    applyStimulus(mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0));
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) runRow(i, vecs[i]);

    // Hand sequence: a lock held without a request keeps the burst count,
    // so m1 still gets exactly four acks in total before m0 takes over.
    @(posedge clk);
    #1;
    applyStimulus(mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0));
    @(posedge clk);
    handVecs.push_back(mk(0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 16'h0));
    handVecs.push_back(mk(0, 2'b11, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 16'h0));
    handVecs.push_back(mk(0, 2'b11, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, f1));
    handVecs.push_back(mk(0, 2'b01, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10, f1));
    handVecs.push_back(mk(0, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 16'h0));
    handVecs.push_back(mk(0, 2'b11, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 16'h0));
    handVecs.push_back(mk(0, 2'b11, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, f1));
    handVecs.push_back(mk(0, 2'b11, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01, f1));
`ifdef ARB_ROUND_ROBIN_EN
    handVecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, D0));
`else
    handVecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, D0));
`endif
    for (int i = 0; i < handVecs.size(); i++) runRow(100 + i, handVecs[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
